// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt controller: FSM encoding,
// register offsets and the id-width helper.
package interrupt_pkg;

   localparam int DEFAULT_N_IRQ = 8;

   localparam logic [15:0] OFS_MASK = 16'd0;
   localparam logic [15:0] OFS_PEND = 16'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational rotating priority encoder: returns the first set bit of vec_i
// found by searching upward from start_i with wrap-around.
module irq_priority_encoder
   import interrupt_pkg::*;
#(
   parameter int N_IRQ = DEFAULT_N_IRQ,
   parameter int ID_W  = id_width(N_IRQ)
) (
   input  logic [N_IRQ-1:0] vec_i,
   input  logic [ID_W-1:0]  start_i,
   output logic             valid_o,
   output logic [ID_W-1:0]  index_o
);

   localparam int PW = ID_W + 1;

   logic [N_IRQ-1:0] rot;
   logic [PW-1:0]    pos;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
      rot     = N_IRQ'({vec_i, vec_i} >> start_i);
      valid_o = |rot;
      pos     = '0;
      for (int k = N_IRQ - 1; k >= 0; k--) begin
         if (rot[k]) pos = PW'(k);
      end
      pos = pos + {1'b0, start_i};
      if (pos >= PW'(N_IRQ)) pos = pos - PW'(N_IRQ);
      index_o = pos[ID_W-1:0];
   end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-capturing interrupt controller with memory-mapped mask/pending and a
// req/ack/done CPU handshake. Define IRQ_ROUND_ROBIN_EN for rotating priority.
module interrupt_controller
   import interrupt_pkg::*;
#(
   parameter int          N_IRQ     = DEFAULT_N_IRQ,
   parameter logic [15:0] BASE_ADDR = 16'hFF10,
   parameter int          ID_W      = id_width(N_IRQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ack,
   input  logic             irq_done,
   input  logic [15:0]      bus_addr,
   input  logic             bus_we,
   input  logic [7:0]       bus_wdata,
   output logic [7:0]       bus_rdata,
   output logic             bus_sel
);

   state_e           state_q, state_d;
   logic [N_IRQ-1:0] irq_q;
   logic [N_IRQ-1:0] pend_q, pend_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic [N_IRQ-1:0] elig, rise, ack_clr, w1c_clr;
   logic [ID_W-1:0]  id_q, id_d;
   logic [ID_W-1:0]  start_idx, win_idx;
   logic             win_valid;
   logic             hit_mask, hit_pend;
   logic             ack_take;

   assign hit_mask = (bus_addr == BASE_ADDR + OFS_MASK);
   assign hit_pend = (bus_addr == BASE_ADDR + OFS_PEND);
   assign bus_sel  = hit_mask | hit_pend;

   always_comb begin
      bus_rdata = '0;
      if (hit_mask)      bus_rdata[N_IRQ-1:0] = mask_q;
      else if (hit_pend) bus_rdata[N_IRQ-1:0] = pend_q;
   end

   assign elig     = pend_q & mask_q;
   assign rise     = irq_in & ~irq_q;
   assign ack_take = (state_q == REQ) && irq_ack;

   always_comb begin
      ack_clr = '0;
      if (ack_take) ack_clr[id_q] = 1'b1;
   end

   // A fresh edge is OR-ed in last so it survives a same-cycle ack or W1C clear.
   assign w1c_clr = (bus_we && hit_pend) ? bus_wdata[N_IRQ-1:0] : '0;
   assign pend_d  = (pend_q & ~w1c_clr & ~ack_clr) | rise;
   assign mask_d  = (bus_we && hit_mask) ? bus_wdata[N_IRQ-1:0] : mask_q;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] ptr_q, ptr_d;

   assign ptr_d     = ack_take ? id_q : ptr_q;
   assign start_idx = (ptr_q == ID_W'(N_IRQ - 1)) ? '0 : ptr_q + ID_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   assign start_idx = '0;
`endif

   irq_priority_encoder #(
      .N_IRQ (N_IRQ),
      .ID_W  (ID_W)
   ) u_prio (
      .vec_i   (elig),
      .start_i (start_idx),
      .valid_o (win_valid),
      .index_o (win_idx)
   );

   // An ack in the same cycle as a withdraw condition is honoured: the CPU saw irq_req high.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      unique case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = REQ;
               id_d    = win_idx;
            end
         end
         REQ: begin
            if (irq_ack)            state_d = SERVICE;
            else if (!elig[id_q])   state_d = IDLE;
         end
         SERVICE: begin
            if (irq_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         irq_q   <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         irq_q   <= irq_in;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
      end
   end

   assign irq_req = (state_q == REQ);
   assign irq_id  = id_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a
// randomized run checked against a transaction-level model of the controller.
`timescale 1ns/1ps
module tb_interrupt_controller;

   localparam int          N    = 8;
   localparam logic [15:0] BASE = 16'hFF10;
   localparam logic [15:0] PEND = 16'hFF11;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] irq_in = '0;
   logic       irq_ack = 1'b0;
   logic       irq_done = 1'b0;
   logic [15:0] bus_addr = '0;
   logic       bus_we = 1'b0;
   logic [7:0] bus_wdata = '0;
   logic       irq_req;
   logic [2:0] irq_id;
   logic [7:0] bus_rdata;
   logic       bus_sel;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   interrupt_controller #(.N_IRQ(N), .BASE_ADDR(BASE), .ID_W(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq_in    (irq_in),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .irq_done  (irq_done),
      .bus_addr  (bus_addr),
      .bus_we    (bus_we),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_sel   (bus_sel)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0] pend;
      logic [7:0] mask;
      logic [7:0] prev;
      bit         req;
      bit         srv;
      int         id;
      int         ptr;
   } mdl_t;

   mdl_t m;

   function automatic int pick(input logic [7:0] e, input int ptr);
      int first = -1;
      int base  = ptr + 1;
`ifndef IRQ_ROUND_ROBIN_EN
      base = 0;
`endif
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (base + k) % N;
         if (first < 0 && e[idx]) first = idx;
      end
      return first;
   endfunction

   function automatic mdl_t model_next(input mdl_t c, input logic [7:0] in_v,
                                       input logic ack, input logic done, input logic we,
                                       input logic [15:0] addr, input logic [7:0] wd);
      mdl_t       n    = c;
      logic [7:0] elig = c.pend & c.mask;
      logic [7:0] p    = c.pend;
      n.prev = in_v;
      if (we && addr == BASE) n.mask = wd;
      if (we && addr == PEND) p = p & ~wd;
      if (c.req && ack) p[c.id] = 1'b0;
      p = p | (in_v & ~c.prev);
      n.pend = p;
      if (c.req) begin
         if (ack) begin
            n.req = 1'b0;
            n.srv = 1'b1;
            n.ptr = c.id;
         end else if (!elig[c.id]) begin
            n.req = 1'b0;
         end
      end else if (c.srv) begin
         if (done) n.srv = 1'b0;
      end else if (elig != 8'h00) begin
         n.req = 1'b1;
         n.id  = pick(elig, c.ptr);
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) m <= '{default: 0};
      else        m <= model_next(m, irq_in, irq_ack, irq_done, bus_we, bus_addr, bus_wdata);
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0;
      bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      bus_addr = a; bus_we = 1'b1; bus_wdata = d;
      @(negedge clk);
      bus_we = 1'b0; bus_wdata = '0; bus_addr = '0;
   endtask

   task automatic pulse(input logic [7:0] v);
      irq_in = v;
      @(negedge clk);
      irq_in = '0;
   endtask

   task automatic ack_pulse();
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   task automatic done_pulse();
      irq_done = 1'b1;
      @(negedge clk);
      irq_done = 1'b0;
   endtask

   task automatic wait_req(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (irq_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      n_checks++; if (irq_req !== 1'b0) $display("FAIL reset_req: got %b want 0", irq_req); else n_pass++;
      n_checks++; if (irq_id !== 3'd0) $display("FAIL reset_id: got %0d want 0", irq_id); else n_pass++;
      bus_write(BASE, 8'hFF);
      pulse(8'h01);
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b1) $display("FAIL pre_reset_req: got %b want 1", irq_req); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if (irq_req !== 1'b0) $display("FAIL async_reset_req: got %b want 0", irq_req); else n_pass++;
      bus_addr = BASE; #1;
      n_checks++; if (bus_rdata !== 8'h00) $display("FAIL async_reset_mask: got %h want 00", bus_rdata); else n_pass++;
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h00) $display("FAIL async_reset_pend: got %h want 00", bus_rdata); else n_pass++;
      bus_addr = '0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (irq_req !== 1'b0) $display("FAIL post_reset_req: got %b want 0", irq_req); else n_pass++;
   endtask

   task automatic test_mask_gate();
      do_reset();
      pulse(8'h08);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (irq_req !== 1'b0) $display("FAIL masked_req_%0d: got %b want 0", i, irq_req); else n_pass++;
         @(negedge clk);
      end
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h08) $display("FAIL masked_pend: got %h want 08", bus_rdata); else n_pass++;
      n_checks++; if (bus_sel !== 1'b1) $display("FAIL sel_pend: got %b want 1", bus_sel); else n_pass++;
      bus_addr = 16'hFF12; #1;
      n_checks++; if (bus_sel !== 1'b0) $display("FAIL sel_other: got %b want 0", bus_sel); else n_pass++;
      n_checks++; if (bus_rdata !== 8'h00) $display("FAIL rdata_other: got %h want 00", bus_rdata); else n_pass++;
      bus_addr = '0;
      bus_write(PEND, 8'h08);
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h00) $display("FAIL w1c_pend: got %h want 00", bus_rdata); else n_pass++;
      bus_addr = '0;
   endtask

   task automatic test_priority_back_to_back();
      do_reset();
      bus_write(BASE, 8'hFF);
      irq_in = 8'h24;
      @(negedge clk);
      irq_in = '0;
      n_checks++; if (irq_req !== 1'b0) $display("FAIL prio_latency1: got %b want 0", irq_req); else n_pass++;
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b1) $display("FAIL prio_req: got %b want 1", irq_req); else n_pass++;
      n_checks++; if (irq_id !== 3'd2) $display("FAIL prio_id: got %0d want 2", irq_id); else n_pass++;
      ack_pulse();
      n_checks++; if (irq_req !== 1'b0) $display("FAIL svc_req: got %b want 0", irq_req); else n_pass++;
      n_checks++; if (irq_id !== 3'd2) $display("FAIL svc_id: got %0d want 2", irq_id); else n_pass++;
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h20) $display("FAIL svc_pend: got %h want 20", bus_rdata); else n_pass++;
      bus_addr = '0;
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b0) $display("FAIL svc_hold: got %b want 0", irq_req); else n_pass++;
      done_pulse();
      n_checks++; if (irq_req !== 1'b0) $display("FAIL b2b_gap: got %b want 0", irq_req); else n_pass++;
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b1) $display("FAIL b2b_req: got %b want 1", irq_req); else n_pass++;
      n_checks++; if (irq_id !== 3'd5) $display("FAIL b2b_id: got %0d want 5", irq_id); else n_pass++;
      ack_pulse();
      done_pulse();
   endtask

   task automatic test_withdraw();
      do_reset();
      bus_write(BASE, 8'hFF);
      pulse(8'h10);
      @(negedge clk);
      n_checks++; if (irq_id !== 3'd4) $display("FAIL wd_id: got %0d want 4", irq_id); else n_pass++;
      bus_write(BASE, 8'hEF);
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b0) $display("FAIL wd_req: got %b want 0", irq_req); else n_pass++;
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h10) $display("FAIL wd_pend: got %h want 10", bus_rdata); else n_pass++;
      bus_addr = BASE; #1;
      n_checks++; if (bus_rdata !== 8'hEF) $display("FAIL wd_mask: got %h want ef", bus_rdata); else n_pass++;
      bus_addr = '0;
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b0) $display("FAIL wd_stay_idle: got %b want 0", irq_req); else n_pass++;
   endtask

   task automatic test_held_line();
      bit ok;
      bit extra = 1'b0;
      do_reset();
      bus_write(BASE, 8'hFF);
      irq_in = 8'h01;
      wait_req(6, ok);
      n_checks++; if (ok !== 1'b1) $display("FAIL held_req_timeout: got %b want 1", ok); else n_pass++;
      ack_pulse();
      repeat (2) @(negedge clk);
      done_pulse();
      repeat (15) begin
         @(negedge clk);
         if (irq_req !== 1'b0) extra = 1'b1;
      end
      irq_in = '0;
      n_checks++; if (extra !== 1'b0) $display("FAIL held_second_req: got %b want 0", extra); else n_pass++;
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h00) $display("FAIL held_pend: got %h want 00", bus_rdata); else n_pass++;
      bus_addr = '0;
   endtask

   task automatic test_ack_collision();
      do_reset();
      bus_write(BASE, 8'hFF);
      pulse(8'h02);
      @(negedge clk);
      n_checks++; if (irq_id !== 3'd1) $display("FAIL col_id: got %0d want 1", irq_id); else n_pass++;
      irq_ack = 1'b1;
      irq_in  = 8'h02;
      @(negedge clk);
      irq_ack = 1'b0;
      irq_in  = '0;
      n_checks++; if (irq_req !== 1'b0) $display("FAIL col_svc: got %b want 0", irq_req); else n_pass++;
      bus_addr = PEND; #1;
      n_checks++; if (bus_rdata !== 8'h02) $display("FAIL col_pend: got %h want 02", bus_rdata); else n_pass++;
      bus_addr = '0;
      done_pulse();
      @(negedge clk);
      n_checks++; if (irq_req !== 1'b1) $display("FAIL col_rereq: got %b want 1", irq_req); else n_pass++;
      n_checks++; if (irq_id !== 3'd1) $display("FAIL col_reid: got %0d want 1", irq_id); else n_pass++;
      ack_pulse();
      done_pulse();
   endtask

   task automatic test_rotation();
      bit ok;
`ifdef IRQ_ROUND_ROBIN_EN
      int expd[4] = '{0, 1, 0, 1};
`else
      int expd[4] = '{0, 0, 0, 0};
`endif
      do_reset();
      bus_write(BASE, 8'hFF);
      pulse(8'h01);
      for (int i = 0; i < 4; i++) begin
         wait_req(6, ok);
         n_checks++; if (ok !== 1'b1) $display("FAIL rot_timeout_%0d: got %b want 1", i, ok); else n_pass++;
         n_checks++; if (irq_id !== 3'(expd[i])) $display("FAIL rot_id_%0d: got %0d want %0d", i, irq_id, expd[i]); else n_pass++;
         ack_pulse();
         pulse(8'h03);
         done_pulse();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [7:0]  elig;
         logic [7:0]  exp_rd;
         logic        exp_sel;
         int          r;
         n_checks++; if (irq_req !== m.req) $display("FAIL rnd_req c=%0d: got %b want %b", c, irq_req, m.req); else n_pass++;
         n_checks++; if (irq_id !== 3'(m.id)) $display("FAIL rnd_id c=%0d: got %0d want %0d", c, irq_id, m.id); else n_pass++;
         elig     = m.pend & m.mask;
         irq_in   = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if (m.req) irq_ack = elig[m.id] ? ($urandom_range(0, 2) == 0) : 1'b0;
         else       irq_ack = ($urandom_range(0, 7) == 0);
         irq_done = m.srv ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         r = $urandom_range(0, 9);
         bus_wdata = 8'($urandom);
         if (r < 2 || r == 4 || r == 5)      bus_addr = BASE;
         else if (r < 4 || r == 6 || r == 7) bus_addr = PEND;
         else                                bus_addr = 16'($urandom_range(0, 65535));
         bus_we = (r < 4) || (r == 9 && $urandom_range(0, 1) == 1);
         exp_sel = (bus_addr == BASE) || (bus_addr == PEND);
         exp_rd  = (bus_addr == BASE) ? m.mask : (bus_addr == PEND) ? m.pend : 8'h00;
         #1;
         n_checks++; if (bus_sel !== exp_sel) $display("FAIL rnd_sel c=%0d: got %b want %b", c, bus_sel, exp_sel); else n_pass++;
         n_checks++; if (bus_rdata !== exp_rd) $display("FAIL rnd_rdata c=%0d: got %h want %h", c, bus_rdata, exp_rd); else n_pass++;
         @(negedge clk);
      end
      irq_in = '0; irq_ack = 1'b0; irq_done = 1'b0;
      bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mask_gate();
      test_priority_back_to_back();
      test_withdraw();
      test_held_line();
      test_ack_collision();
      test_rotation();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
